// File: rtl/easyaxi_pkg.sv
// AXI encodings, field widths and a ceil-log2 helper shared by the EasyAXI
// read and write slaves.
package easyaxi_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/easyaxi_rd_slv_ost_if.sv
// AR and R channel bundle of an AXI read port.
interface easyaxi_rd_slv_ost_if
  import easyaxi_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic                 arvalid;
  logic                 arready;
  logic [ID_W-1:0]      arid;
  logic [ADDR_W-1:0]    araddr;
  logic [LEN_W-1:0]     arlen;
  logic [SIZE_W-1:0]    arsize;
  logic [BURST_W-1:0]   arburst;

  logic                 rvalid;
  logic                 rready;
  logic [ID_W-1:0]      rid;
  logic [DATA_W-1:0]    rdata;
  logic [RESP_W-1:0]    rresp;
  logic                 rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );

endinterface

// File: rtl/easyaxi_burst_addr.sv
// Combinational AXI beat-address generator for FIXED/INCR/WRAP bursts.
module easyaxi_burst_addr
  import easyaxi_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [LEN_W-1:0]   len,
  input  logic [SIZE_W-1:0]  size,
  input  logic [BURST_W-1:0] burst,
  input  logic [LEN_W-1:0]   beat,
  output logic [ADDR_W-1:0]  beat_addr
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] aligned;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_addr;

  always_comb begin
    bytes     = ADDR_W'(1) << size;
    aligned   = start_addr & ~(bytes - ADDR_W'(1));
    offset    = ADDR_W'(beat) << size;
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    incr_addr = aligned + offset;
    // window base stays fixed, only the in-window offset advances
    wrap_addr = (aligned & ~wrap_mask) | (incr_addr & wrap_mask);
    if (beat == '0 || burst == BURST_FIXED) beat_addr = start_addr;
    else if (burst == BURST_WRAP)           beat_addr = wrap_addr;
    else                                    beat_addr = incr_addr;
  end

endmodule

// File: rtl/easyaxi_rd_slv_ost.sv
// AXI read slave with OST_DEPTH outstanding requests, returned strictly in
// acceptance order, each released RD_LAT cycles after its AR handshake.
module easyaxi_rd_slv_ost
  import easyaxi_pkg::*;
#(
  parameter int              OST_DEPTH     = 8,
  parameter int              ADDR_W        = 16,
  parameter int              ID_W          = 4,
  parameter int              DATA_W        = 32,
  parameter int              MAX_BURST_LEN = 8,
  parameter int              RD_LAT        = 2,
  parameter logic [63:0]     BASE_ADDR     = 64'h0,
  parameter logic [63:0]     WIN_SIZE      = 64'h1000,
  parameter logic [ID_W-1:0] ERR_ID        = 'hF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  easyaxi_rd_slv_ost_if.slave   axi_slv
);

  localparam int PTR_W    = clog2(OST_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int LAT_W    = clog2(RD_LAT + 2);
  localparam int SIZE_MAX = clog2(DATA_W / 8);

  logic [ID_W-1:0]    id_q    [OST_DEPTH];
  logic [ADDR_W-1:0]  addr_q  [OST_DEPTH];
  logic [LEN_W-1:0]   len_q   [OST_DEPTH];
  logic [SIZE_W-1:0]  size_q  [OST_DEPTH];
  logic [BURST_W-1:0] burst_q [OST_DEPTH];
  logic [RESP_W-1:0]  resp_q  [OST_DEPTH];
  logic               errid_q [OST_DEPTH];
  logic               vld_q   [OST_DEPTH];
  logic [LAT_W-1:0]   lat_q   [OST_DEPTH];

  logic [PTR_W-1:0]   req_ptr, cmp_ptr;
  logic [CNT_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   beat_q;
  logic               rdy_en_q;
  logic               head_valid, head_last;
  logic               ar_hs, r_hs, last_hs;
  logic               in_win, bad_req;
  logic [RESP_W-1:0]  ar_resp;
  logic [ADDR_W-1:0]  head_addr;

  // error class is resolved once at acceptance and stored with the slot
  always_comb begin
    in_win  = (64'(axi_slv.araddr) >= BASE_ADDR) &&
              (64'(axi_slv.araddr) < BASE_ADDR + WIN_SIZE);
    bad_req = (axi_slv.arburst == 2'b11) ||
              (axi_slv.arburst == BURST_WRAP &&
               !(axi_slv.arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
              (int'(axi_slv.arlen) + 1 > MAX_BURST_LEN) ||
              (int'(axi_slv.arsize) > SIZE_MAX);
    if (!in_win)      ar_resp = RESP_DECERR;
    else if (bad_req) ar_resp = RESP_SLVERR;
    else              ar_resp = RESP_OKAY;
  end

  assign head_valid = vld_q[cmp_ptr] && (lat_q[cmp_ptr] == '0);
  assign head_last  = (beat_q == len_q[cmp_ptr]);
  assign ar_hs      = axi_slv.arvalid && axi_slv.arready;
  assign r_hs       = head_valid && axi_slv.rready;
  assign last_hs    = r_hs && head_last;

  assign axi_slv.arready = rdy_en_q && enable && (cnt_q != CNT_W'(OST_DEPTH));
  assign axi_slv.rvalid  = head_valid;
  assign axi_slv.rlast   = head_valid && head_last;
  assign axi_slv.rid     = head_valid ? id_q[cmp_ptr] : '0;
  assign axi_slv.rdata   = head_valid ? DATA_W'({id_q[cmp_ptr], head_addr}) : '0;

  always_comb begin
    axi_slv.rresp = RESP_OKAY;
    if (head_valid) begin
      if (resp_q[cmp_ptr] != RESP_OKAY)      axi_slv.rresp = resp_q[cmp_ptr];
      else if (head_last && errid_q[cmp_ptr]) axi_slv.rresp = RESP_SLVERR;
    end
  end

  easyaxi_burst_addr #(.ADDR_W(ADDR_W)) u_burst_addr (
    .start_addr (addr_q[cmp_ptr]),
    .len        (len_q[cmp_ptr]),
    .size       (size_q[cmp_ptr]),
    .burst      (burst_q[cmp_ptr]),
    .beat       (beat_q),
    .beat_addr  (head_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      req_ptr  <= '0;
      cmp_ptr  <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      for (int i = 0; i < OST_DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        lat_q[i] <= '0;
      end
    end else begin
      rdy_en_q <= 1'b1;
      for (int i = 0; i < OST_DEPTH; i++) begin
        if (lat_q[i] != '0) lat_q[i] <= lat_q[i] - LAT_W'(1);
      end
      if (r_hs) beat_q <= last_hs ? '0 : beat_q + LEN_W'(1);
      if (last_hs) begin
        vld_q[cmp_ptr] <= 1'b0;
        cmp_ptr        <= cmp_ptr + PTR_W'(1);
      end
      // a load overrides the decrement above for the newly written slot
      if (ar_hs) begin
        vld_q[req_ptr] <= 1'b1;
        lat_q[req_ptr] <= LAT_W'(RD_LAT);
        req_ptr        <= req_ptr + PTR_W'(1);
      end
      cnt_q <= cnt_q + CNT_W'(ar_hs) - CNT_W'(last_hs);
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      id_q[req_ptr]    <= axi_slv.arid;
      addr_q[req_ptr]  <= axi_slv.araddr;
      len_q[req_ptr]   <= axi_slv.arlen;
      size_q[req_ptr]  <= axi_slv.arsize;
      burst_q[req_ptr] <= axi_slv.arburst;
      resp_q[req_ptr]  <= ar_resp;
      errid_q[req_ptr] <= (axi_slv.arid == ERR_ID);
    end
  end

endmodule

// File: tb/tb_easyaxi_rd_slv_ost.sv
// Randomised scoreboard bench for easyaxi_rd_slv_ost: expected beats are
// queued at each AR handshake and checked by an independent R monitor.
module tb_easyaxi_rd_slv_ost;
  import easyaxi_pkg::*;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int OST    = 8;
  localparam int MAXB   = 8;
  localparam int LAT    = 2;

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    bit                chk_data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  bit   rr_rand = 0;
  bit   en_rand = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  beat_t sb[$];

  easyaxi_rd_slv_ost_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  easyaxi_rd_slv_ost #(
    .OST_DEPTH(OST), .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W),
    .MAX_BURST_LEN(MAXB), .RD_LAT(LAT), .BASE_ADDR(64'h0),
    .WIN_SIZE(64'h1000), .ERR_ID(4'hF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .axi_slv(axi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference address: arithmetic on byte counts, wrap via modulo
  function automatic logic [ADDR_W-1:0] model_addr(input int unsigned addr, input int unsigned len,
                                                   input int unsigned size, input int unsigned burst,
                                                   input int unsigned n);
    int unsigned bytes, aligned, wlen, lo, r;
    bytes   = 1 << size;
    aligned = (addr / bytes) * bytes;
    if (n == 0 || burst == 0) r = addr;
    else if (burst == 2) begin
      wlen = (len + 1) * bytes;
      lo   = (aligned / wlen) * wlen;
      r    = lo + ((aligned - lo) + n * bytes) % wlen;
    end else r = aligned + n * bytes;
    r = r % (1 << ADDR_W);
    return r[ADDR_W-1:0];
  endfunction

  function automatic void push_expected(input int unsigned id, input int unsigned addr,
                                        input int unsigned len, input int unsigned size,
                                        input int unsigned burst);
    beat_t b;
    bit in_win, wrap_bad, bad;
    logic [ADDR_W-1:0] ma;
    in_win   = addr < 'h1000;
    wrap_bad = (burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15);
    bad      = (burst == 3) || wrap_bad || (len + 1 > MAXB) || ((1 << size) > DATA_W / 8);
    for (int unsigned n = 0; n <= len; n++) begin
      ma = model_addr(addr, len, size, burst, n);
      b.id       = ID_W'(id);
      b.data     = (DATA_W'(id) << ADDR_W) | DATA_W'(ma);
      b.last     = (n == len);
      b.chk_data = !(burst == 3 || wrap_bad);
      if (!in_win)                      b.resp = RESP_DECERR;
      else if (bad)                     b.resp = RESP_SLVERR;
      else if (n == len && id == 'hF)   b.resp = RESP_SLVERR;
      else                              b.resp = RESP_OKAY;
      sb.push_back(b);
    end
  endfunction

  task automatic send_ar(input int unsigned id, input int unsigned addr, input int unsigned len,
                         input int unsigned size, input int unsigned burst);
    int g;
    g = 0;
    axi.arvalid = 1'b1;
    axi.arid    = ID_W'(id);
    axi.araddr  = ADDR_W'(addr);
    axi.arlen   = 8'(len);
    axi.arsize  = 3'(size);
    axi.arburst = 2'(burst);
    @(negedge clk);
    while (!axi.arready && g < 500) begin
      g++;
      @(negedge clk);
    end
    chk("ar_accept", axi.arready, 1'b1);
    if (axi.arready) push_expected(id, addr, len, size, burst);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic one_burst(input int unsigned id, input int unsigned addr, input int unsigned len,
                           input int unsigned size, input int unsigned burst);
    send_ar(id, addr, len, size, burst);
    axi.arvalid = 1'b0;
    wait_drain();
  endtask

  // R monitor: pops the scoreboard on each handshake, checks stall stability
  initial begin : monitor
    beat_t e;
    logic prev_stall;
    logic [ID_W-1:0] p_rid;
    logic [DATA_W-1:0] p_data;
    logic [1:0] p_resp;
    logic p_last;
    prev_stall = 1'b0;
    p_rid = '0; p_data = '0; p_resp = '0; p_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("stall_rvalid", axi.rvalid, 1'b1);
        chk("stall_rid", axi.rid, p_rid);
        chk("stall_rdata", axi.rdata, p_data);
        chk("stall_rresp", axi.rresp, p_resp);
        chk("stall_rlast", axi.rlast, p_last);
      end
      if (axi.rvalid && axi.rready) begin
        if (sb.size() == 0) chk("beat_expected", axi.rvalid, 1'b0);
        else begin
          e = sb.pop_front();
          chk("rid", axi.rid, e.id);
          if (e.chk_data) chk("rdata", axi.rdata, e.data);
          chk("rresp", axi.rresp, e.resp);
          chk("rlast", axi.rlast, e.last);
        end
      end
      prev_stall = axi.rvalid && !axi.rready;
      p_rid = axi.rid; p_data = axi.rdata; p_resp = axi.rresp; p_last = axi.rlast;
    end
  end

  initial begin : randomiser
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) axi.rready = ($urandom % 3) != 0;
      if (en_rand) enable = ($urandom % 4) != 0;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d beats still queued", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc;
    int unsigned r_len, r_burst;
    axi.arvalid = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0;
    axi.arsize = '0; axi.arburst = '0; axi.rready = 1'b0;
    rst_n = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", axi.arready, 1'b0);
    chk("rst_rvalid", axi.rvalid, 1'b0);
    chk("rst_rid", axi.rid, '0);
    chk("rst_rdata", axi.rdata, '0);
    chk("rst_rresp", axi.rresp, RESP_OKAY);
    chk("rst_rlast", axi.rlast, 1'b0);
    rst_n = 1'b1;
    #1 chk("arready_at_release", axi.arready, 1'b0);
    @(negedge clk);
    chk("arready_rise", axi.arready, 1'b1);
    @(posedge clk);
    #1;

    // single INCR burst with first-beat latency
    axi.rready = 1'b1;
    send_ar(3, 'h10, 3, 2, 1);
    axi.arvalid = 1'b0;
    @(negedge clk); chk("lat_edge_t", axi.rvalid, 1'b0);
    @(negedge clk); chk("lat_edge_t1", axi.rvalid, 1'b0);
    @(negedge clk); chk("lat_edge_t2", axi.rvalid, 1'b1);
    wait_drain();

    one_burst(1, 'h38, 3, 3, 2);   // WRAP 0x38,0x20,0x28,0x30
    one_burst(2, 'h2000, 2, 2, 1); // outside window
    one_burst(4, 'h40, 1, 2, 3);   // reserved burst
    one_burst(5, 'h80, 8, 2, 1);   // too long
    one_burst(6, 'h90, 2, 2, 2);   // illegal wrap length
    one_burst(15, 'h100, 1, 2, 1); // error id: OKAY then SLVERR
    one_burst(15, 'h3000, 1, 2, 1);
    one_burst(7, 'h0FFC, 0, 2, 0);

    enable = 1'b0;
    @(negedge clk); chk("enable_low_arready", axi.arready, 1'b0);
    @(posedge clk); #1 enable = 1'b1;

    // fill all slots under backpressure, then drain with no bubbles
    axi.rready = 1'b0;
    for (int i = 0; i < OST; i++) send_ar(i, i * 'h40, i % 4, 2, 1);
    axi.arid = 4'd9; axi.araddr = 16'h0300;
    @(negedge clk); chk("full_arready", axi.arready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk("full_arready_hold", axi.arready, 1'b0);
    @(posedge clk); #1 axi.arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 axi.rready = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (axi.rvalid && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    chk("no_bubble_beats", 64'(cyc), 64'd20);
    wait_drain();
    one_burst(9, 'h300, 2, 1, 1);

    // random traffic with random rready/enable across many pointer wraps
    rr_rand = 1;
    en_rand = 1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom % 3 == 0) begin
        axi.arvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      r_len   = ($urandom % 5 == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
      r_burst = ($urandom % 6 == 0) ? 3 : $urandom_range(0, 2);
      if (r_burst == 2 && ($urandom % 4 != 0)) r_len = (2 << $urandom_range(0, 2)) - 1;
      send_ar($urandom % 16, $urandom_range(0, 'h17FF), r_len, $urandom_range(0, 3), r_burst);
    end
    axi.arvalid = 1'b0;
    rr_rand = 0;
    en_rand = 0;
    @(posedge clk);
    #2 axi.rready = 1'b1;
    enable = 1'b1;
    wait_drain();

    // reset in the middle of beat 2
    send_ar(2, 'h100, 3, 2, 1);
    axi.arvalid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_rvalid", axi.rvalid, 1'b1);
    chk("pre_rst_rdata", axi.rdata, 32'h0002_0108);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_arready", axi.arready, 1'b0);
    chk("mid_rst_rvalid", axi.rvalid, 1'b0);
    chk("mid_rst_rid", axi.rid, '0);
    chk("mid_rst_rdata", axi.rdata, '0);
    chk("mid_rst_rresp", axi.rresp, RESP_OKAY);
    chk("mid_rst_rlast", axi.rlast, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    one_burst(5, 'h200, 1, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
